// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one-cycle-latency reads to the
// I-SRAM, queues {pc, instr} pairs and hands them to decode via valid/ready.
// A redirect flushes the queue and restarts fetch at the new PC.
module riscv_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AW       = 2
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        I_MEM_CSN,
  output logic [31:0] I_MEM_ADDR,
  input  logic [31:0] I_MEM_DI,
  input  logic        REDIRECT_VALID,
  input  logic [31:0] REDIRECT_PC,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] OUT_PC,
  output logic [31:0] OUT_INSTR
);

  typedef enum logic {
    ST_RUN,
    ST_DROP
  } state_t;

  localparam logic [AW+1:0] DEPTH_OCC = (AW+2)'(DEPTH);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);

  state_t        state_q, state_d;
  logic [31:0]   pc_q;
  logic [31:0]   issued_pc_q;
  logic          inflight_q;
  logic [AW:0]   count_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic          issue;
  logic          push;
  logic          pop;
  logic [AW+1:0] occupancy;

  // Issue/capture/pop decisions and next FSM state. Issue counts the read in
  // flight as occupied so a returning word always has a free slot.
  always_comb begin
    state_d   = ST_RUN;
    occupancy = {1'b0, count_q} + {{(AW+1){1'b0}}, inflight_q};
    issue     = !RST && !REDIRECT_VALID && (occupancy < DEPTH_OCC);
    push      = !RST && !REDIRECT_VALID && inflight_q && (state_q == ST_RUN);
    pop       = OUT_VALID && OUT_READY && !REDIRECT_VALID;
    if (REDIRECT_VALID && inflight_q) begin
      state_d = ST_DROP;
    end
  end

  // Memory request and queue head outputs; forced to their idle values in reset.
  always_comb begin
    I_MEM_CSN  = !issue;
    I_MEM_ADDR = RST ? RESET_PC : pc_q;
    OUT_VALID  = !RST && (count_q != '0);
    OUT_PC     = RST ? '0 : pc_mem[rd_ptr_q];
    OUT_INSTR  = RST ? '0 : instr_mem[rd_ptr_q];
  end

  // PC, pointers, occupancy, in-flight flag and FSM state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      issued_pc_q <= RESET_PC;
      inflight_q  <= 1'b0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (issue) begin
        pc_q        <= pc_q + 32'd4;
        issued_pc_q <= pc_q;
      end
      if (REDIRECT_VALID) begin
        pc_q     <= REDIRECT_PC & ~32'h3;
        count_q  <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        if (push && !pop)      count_q <= count_q + (AW+1)'(1);
        else if (!push && pop) count_q <= count_q - (AW+1)'(1);
      end
    end
  end

  // Queue storage: captures the returning SRAM word with the PC it was fetched from.
  always_ff @(posedge CLK) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= issued_pc_q;
      instr_mem[wr_ptr_q] <= I_MEM_DI;
    end
  end

  // The issue throttle must make a push into a full queue impossible.
  assert property (@(posedge CLK) disable iff (RST) !(push && (count_q == DEPTH_CNT)));

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Bench for riscv_fetch_unit: table-driven cycle vectors for start-up,
// backpressure and mid-stream redirect, plus hand sequences for
// redirect/pop collision, address wrap with random stalls, and reset under load.
module tb_riscv_fetch_unit;

  logic        CLK;
  logic        RST;
  logic        I_MEM_CSN;
  logic [31:0] I_MEM_ADDR;
  logic [31:0] I_MEM_DI;
  logic        REDIRECT_VALID;
  logic [31:0] REDIRECT_PC;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_PC;
  logic [31:0] OUT_INSTR;

  int n_cmp;
  int n_bad;

  riscv_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4),
    .AW       (2)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .I_MEM_CSN      (I_MEM_CSN),
    .I_MEM_ADDR     (I_MEM_ADDR),
    .I_MEM_DI       (I_MEM_DI),
    .REDIRECT_VALID (REDIRECT_VALID),
    .REDIRECT_PC    (REDIRECT_PC),
    .OUT_VALID      (OUT_VALID),
    .OUT_READY      (OUT_READY),
    .OUT_PC         (OUT_PC),
    .OUT_INSTR      (OUT_INSTR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory contents: word i holds 0x1000 + i.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'h1000 + {2'b00, addr[31:2]};
  endfunction

  // One-cycle-latency SRAM model.
  always @(posedge CLK) begin
    if (!I_MEM_CSN) I_MEM_DI <= mem_word(I_MEM_ADDR);
  end

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_csn;
    logic [31:0] e_addr;
    logic        e_valid;
    logic        chk_out;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy,
                     input logic e_csn, input logic [31:0] e_addr, input logic e_valid,
                     input logic chk_out, input logic [31:0] e_pc, input logic [31:0] e_instr);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.e_csn = e_csn; v.e_addr = e_addr; v.e_valid = e_valid;
    v.chk_out = chk_out; v.e_pc = e_pc; v.e_instr = e_instr;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive inputs just after the rising edge, then wait for the falling edge to sample.
  task automatic drive(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
    @(posedge CLK);
    #1;
    RST = rst; REDIRECT_VALID = rv; REDIRECT_PC = rpc; OUT_READY = rdy;
    @(negedge CLK);
  endtask

  task automatic chk_req(input string name, input logic csn, input logic [31:0] addr);
    chk({name, ".csn"}, {31'd0, I_MEM_CSN}, {31'd0, csn});
    if (!csn) chk({name, ".addr"}, I_MEM_ADDR, addr);
  endtask

  task automatic chk_head(input string name, input logic valid, input logic [31:0] pc,
                          input logic [31:0] instr);
    chk({name, ".valid"}, {31'd0, OUT_VALID}, {31'd0, valid});
    if (valid) begin
      chk({name, ".pc"}, OUT_PC, pc);
      chk({name, ".instr"}, OUT_INSTR, instr);
    end
  endtask

  logic [31:0] exp_pc;
  logic [31:0] prev_pc;
  logic        prev_hold;
  logic        rdy;
  int          pops;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    RST = 1'b1; REDIRECT_VALID = 1'b0; REDIRECT_PC = '0; OUT_READY = 1'b1;

    // T1 start-up then T3 redirect to 0x103 while a read is in flight (cycle 5).
    add(1,0,0,1, 1,32'h0,0, 1,32'h0,32'h0);
    add(1,0,0,1, 1,32'h0,0, 1,32'h0,32'h0);
    add(0,0,0,1, 0,32'h0,0, 0,0,0);
    add(0,0,0,1, 0,32'h4,0, 0,0,0);
    add(0,0,0,1, 0,32'h8,1, 1,32'h0,32'h1000);
    add(0,0,0,1, 0,32'hC,1, 1,32'h4,32'h1001);
    add(0,0,0,1, 0,32'h10,1, 1,32'h8,32'h1002);
    add(0,1,32'h103,1, 1,32'h14,1, 1,32'hC,32'h1003);
    add(0,0,0,1, 0,32'h100,0, 0,0,0);
    add(0,0,0,1, 0,32'h104,0, 0,0,0);
    add(0,0,0,1, 0,32'h108,1, 1,32'h100,32'h1040);
    add(0,0,0,1, 0,32'h10C,1, 1,32'h104,32'h1041);
    // T2 backpressure from cycle 0, then drain.
    add(1,0,0,0, 1,32'h0,0, 1,32'h0,32'h0);
    add(1,0,0,0, 1,32'h0,0, 1,32'h0,32'h0);
    add(0,0,0,0, 0,32'h0,0, 0,0,0);
    add(0,0,0,0, 0,32'h4,0, 0,0,0);
    add(0,0,0,0, 0,32'h8,1, 1,32'h0,32'h1000);
    add(0,0,0,0, 0,32'hC,1, 1,32'h0,32'h1000);
    add(0,0,0,0, 1,32'h10,1, 1,32'h0,32'h1000);
    add(0,0,0,0, 1,32'h10,1, 1,32'h0,32'h1000);
    add(0,0,0,0, 1,32'h10,1, 1,32'h0,32'h1000);
    add(0,0,0,1, 1,32'h10,1, 1,32'h0,32'h1000);
    add(0,0,0,1, 0,32'h10,1, 1,32'h4,32'h1001);
    add(0,0,0,1, 0,32'h14,1, 1,32'h8,32'h1002);
    add(0,0,0,1, 0,32'h18,1, 1,32'hC,32'h1003);
    add(0,0,0,1, 0,32'h1C,1, 1,32'h10,32'h1004);

    for (int i = 0; i < tbl.size(); i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      drive(tbl[i].rst, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
      chk({nm, ".csn"}, {31'd0, I_MEM_CSN}, {31'd0, tbl[i].e_csn});
      chk({nm, ".addr"}, I_MEM_ADDR, tbl[i].e_addr);
      chk({nm, ".valid"}, {31'd0, OUT_VALID}, {31'd0, tbl[i].e_valid});
      if (tbl[i].chk_out) begin
        chk({nm, ".pc"}, OUT_PC, tbl[i].e_pc);
        chk({nm, ".instr"}, OUT_INSTR, tbl[i].e_instr);
      end
    end

    // T4 redirect colliding with a pop while two entries are queued.
    drive(1,0,0,0);
    drive(1,0,0,0);
    drive(0,0,0,0);
    drive(0,0,0,0);
    drive(0,0,0,0);
    drive(0,1,32'h200,1);
    chk_req("t4.redir", 1'b1, 32'h0);
    chk_head("t4.redir", 1'b1, 32'h0, 32'h1000);
    drive(0,0,0,1);
    chk_req("t4.c1", 1'b0, 32'h200);
    chk_head("t4.c1", 1'b0, 0, 0);
    drive(0,0,0,1);
    chk_req("t4.c2", 1'b0, 32'h204);
    chk_head("t4.c2", 1'b0, 0, 0);
    drive(0,0,0,1);
    chk_head("t4.c3", 1'b1, 32'h200, 32'h1080);
    drive(0,0,0,1);
    chk_head("t4.c4", 1'b1, 32'h204, 32'h1081);

    // T5 address wrap, then random stalls checked against an in-order scoreboard.
    drive(0,1,32'hFFFF_FFF8,1);
    drive(0,0,0,1);
    chk_req("t5.c0", 1'b0, 32'hFFFF_FFF8);
    drive(0,0,0,1);
    chk_req("t5.c1", 1'b0, 32'hFFFF_FFFC);
    drive(0,0,0,1);
    chk_req("t5.c2", 1'b0, 32'h0000_0000);
    chk_head("t5.c2", 1'b1, 32'hFFFF_FFF8, 32'h4000_0FFE);
    drive(0,0,0,1);
    chk_head("t5.c3", 1'b1, 32'hFFFF_FFFC, 32'h4000_0FFF);
    drive(0,0,0,1);
    chk_head("t5.c4", 1'b1, 32'h0000_0000, 32'h0000_1000);
    exp_pc    = 32'h4;
    prev_hold = 1'b0;
    prev_pc   = '0;
    pops      = 0;
    for (int i = 0; i < 500; i++) begin
      rdy = 1'($urandom_range(0, 1));
      drive(0,0,0,rdy);
      if (prev_hold) chk("t5.hold", OUT_PC, prev_pc);
      if (OUT_VALID && OUT_READY) begin
        chk("t5.sb.pc", OUT_PC, exp_pc);
        chk("t5.sb.instr", OUT_INSTR, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      prev_hold = OUT_VALID && !OUT_READY;
      prev_pc   = OUT_PC;
    end
    chk("t5.pops_ge_100", {31'd0, pops >= 100}, 32'd1);

    // T6 reset with a full queue and a simultaneous redirect, then clean restart.
    for (int i = 0; i < 8; i++) drive(0,0,0,0);
    chk_req("t6.full", 1'b1, 32'h0);
    chk_head("t6.full", 1'b1, exp_pc, mem_word(exp_pc));
    drive(1,1,32'h500,1);
    chk("t6.rst0.csn", {31'd0, I_MEM_CSN}, 32'd1);
    chk("t6.rst0.addr", I_MEM_ADDR, 32'h0);
    chk("t6.rst0.valid", {31'd0, OUT_VALID}, 32'd0);
    chk("t6.rst0.pc", OUT_PC, 32'h0);
    chk("t6.rst0.instr", OUT_INSTR, 32'h0);
    drive(1,1,32'h500,1);
    chk("t6.rst1.csn", {31'd0, I_MEM_CSN}, 32'd1);
    chk("t6.rst1.addr", I_MEM_ADDR, 32'h0);
    chk("t6.rst1.valid", {31'd0, OUT_VALID}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      drive(0,0,0,1);
      chk_req($sformatf("t6.run%0d", i), 1'b0, 32'(4 * i));
      chk_head($sformatf("t6.run%0d", i), i >= 2, 32'(4 * (i - 2)), 32'(32'h1000 + i - 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
